// File: rtl/udma_uart_pkg.sv
// Shared UART definitions: FSM state encoding, data-length and stop-bit encodings,
// and small helpers for data masking and parity. Used by both the transmitter and receiver.
package udma_uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4
    } uart_state_e;

    // The number of data bits is 5 + the encoded value.
    typedef enum logic [1:0] {
        BITS_5 = 2'd0,
        BITS_6 = 2'd1,
        BITS_7 = 2'd2,
        BITS_8 = 2'd3
    } uart_bits_e;

    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } uart_stop_e;

    localparam int unsigned UART_DATA_W = 8;

    // Index of the last data bit in a frame.
    function automatic logic [2:0] last_data_idx(input uart_bits_e bits);
        return 3'd4 + {1'b0, bits};
    endfunction

    function automatic logic [UART_DATA_W-1:0] data_mask(input uart_bits_e bits);
        return 8'hFF >> (3'd3 - {1'b0, bits});
    endfunction

    // Even parity covers only the bits that are actually transmitted.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data,
                                         input uart_bits_e             bits);
        return ^(data & data_mask(bits));
    endfunction

endpackage

// File: rtl/udma_uart_baudgen.sv
// Bit-period counter: tick_o is high on the last cycle of every bit (div_i + 1 cycles per bit).
// restart_i forces the counter back to the start of a bit period.
module udma_uart_baudgen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // The counter never runs past div_i, so an all-ones divider cannot wrap it.
    assign tick_o = (r_cnt == div_i);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent simulation races.
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (restart_i || tick_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/udma_uart_tx.sv
// uDMA UART transmitter: valid/ready byte input, 5-8 data bits, optional even parity, 1/2 stop bits.
// Optional macro UDMA_UART_TX_CTS_EN adds a synchronised active-low cts_ni that gates tx_ready_o.
module udma_uart_tx
    import udma_uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
`ifdef UDMA_UART_TX_CTS_EN
    input  logic                 cts_ni,
`endif
    output logic                 tx_o,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_parity_en_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_stop_bits_i,
    input  logic [7:0]           tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 busy_o
);

    uart_state_e          r_state;
    logic [7:0]           r_data;
    logic [DIV_WIDTH-1:0] r_div;
    uart_bits_e           r_bits;
    logic                 r_parity_en;
    uart_stop_e           r_stop;
    logic                 r_parity;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;

    logic                 w_cts_ok;
    logic                 w_handshake;
    logic                 w_tick;
    logic                 w_restart;

`ifdef UDMA_UART_TX_CTS_EN
    logic [1:0] r_cts_sync;

    // Two-flop synchroniser; resets to "not clear to send".
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cts_sync <= 2'b11;
        end else begin
            r_cts_sync <= {r_cts_sync[0], cts_ni};
        end
    end

    assign w_cts_ok = ~r_cts_sync[1];
`else
    assign w_cts_ok = 1'b1;
`endif

    // Ready is forced low while reset is held, even though reset only acts at the edge.
    assign tx_ready_o  = rstn_i & cfg_en_i & w_cts_ok & (r_state == IDLE);
    assign w_handshake = tx_valid_i & tx_ready_o;
    assign busy_o      = (r_state != IDLE);
    assign tx_o        = r_tx;

    // Holding the counter in restart while idle aligns the first bit to the handshake edge.
    assign w_restart = (r_state == IDLE);

    udma_uart_baudgen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baudgen (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .restart_i (w_restart),
        .div_i     (r_div),
        .tick_o    (w_tick)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: every register here, including the data shift register and the latched
        // frame configuration, gets a reset value so no X can reach tx_o after reset.
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_tx        <= 1'b1;
            r_data      <= 8'hFF;
            r_div       <= '0;
            r_bits      <= BITS_8;
            r_parity_en <= 1'b0;
            r_stop      <= STOP_1;
            r_parity    <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
        end else if (!cfg_en_i) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_handshake) begin
                        r_data      <= tx_data_i;
                        r_div       <= cfg_div_i;
                        r_bits      <= uart_bits_e'(cfg_bits_i);
                        r_parity_en <= cfg_parity_en_i;
                        r_stop      <= uart_stop_e'(cfg_stop_bits_i);
                        r_parity    <= even_parity(tx_data_i, uart_bits_e'(cfg_bits_i));
                        r_bit_cnt   <= '0;
                        r_stop_cnt  <= 1'b0;
                        r_tx        <= 1'b0;
                        r_state     <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (w_tick) begin
                        r_tx    <= r_data[0];
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == last_data_idx(r_bits)) begin
                            if (r_parity_en) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP_BIT;
                            end
                        end else begin
                            r_data    <= {1'b1, r_data[7:1]};
                            r_tx      <= r_data[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP_BIT;
                    end
                end

                STOP_BIT: begin
                    if (w_tick) begin
                        if ((r_stop == STOP_2) && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_uart_tx.sv
// Directed bench for udma_uart_tx; waveforms are captured per cycle and compared with hand-derived frames.
// Define UDMA_UART_TX_CTS_EN for both bench and RTL to exercise the clear-to-send option.
module tb_udma_uart_tx;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        tx_o;
    logic [15:0] cfg_div_i;
    logic        cfg_en_i;
    logic        cfg_parity_en_i;
    logic [1:0]  cfg_bits_i;
    logic        cfg_stop_bits_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        busy_o;
`ifdef UDMA_UART_TX_CTS_EN
    logic        cts_ni;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    udma_uart_tx #(
        .DIV_WIDTH (16)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
`ifdef UDMA_UART_TX_CTS_EN
        .cts_ni          (cts_ni),
`endif
        .tx_o            (tx_o),
        .cfg_div_i       (cfg_div_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_bits_i      (cfg_bits_i),
        .cfg_stop_bits_i (cfg_stop_bits_i),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .busy_o          (busy_o)
    );

    // Expands a list of line bits (bit i = i-th bit on the wire) into a per-cycle waveform;
    // cycles after the frame read as idle-high, cycles past 'total' read as 0.
    function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits,
                                           input int div, input int total);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < total; k++) begin
            int idx;
            idx  = k / (div + 1);
            w[k] = (idx < nbits) ? bits[idx] : 1'b1;
        end
        return w;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] w;
        w = '0;
        for (int k = lo; k < hi; k++) w[k] = 1'b1;
        return w;
    endfunction

    task automatic set_cfg(input int div, input int bits, input logic par, input logic stop);
        cfg_div_i       = 16'(div);
        cfg_bits_i      = 2'(bits);
        cfg_parity_en_i = par;
        cfg_stop_bits_i = stop;
    endtask

    // Offers one byte at a negedge, then samples n cycles; sample 0 is the cycle after the handshake.
    task automatic run_frame(input logic [7:0] data, input int n, input int drop_valid_at,
                             input int drop_en_at, input int rst_at, input logic scramble,
                             output logic [63:0] tx_w, output logic [63:0] busy_w,
                             output logic [63:0] rdy_w);
        tx_w   = '0;
        busy_w = '0;
        rdy_w  = '0;
        @(negedge clk_i);
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            tx_w[k]   = tx_o;
            busy_w[k] = busy_o;
            rdy_w[k]  = tx_ready_o;
            if (k == drop_valid_at) tx_valid_i = 1'b0;
            if (k == drop_en_at)    cfg_en_i   = 1'b0;
            if (k == rst_at)        rstn_i     = 1'b0;
            if (k == rst_at + 1)    rstn_i     = 1'b1;
            if (scramble && k == 0) begin
                set_cfg(0, 0, 1'b1, 1'b1);
                tx_data_i = 8'h00;
            end
        end
    endtask

    task automatic test_reset;
        rstn_i = 1'b0;
        cfg_en_i = 1'b1;
        tx_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (tx_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx got=%b exp=1", tx_o);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o);
        end
        n_checks++;
        if (tx_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=0", tx_ready_o);
        end
        rstn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (tx_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset got=%b exp=1", tx_ready_o);
        end
    endtask

    // div=3 8N1 0xA5 -> 0,1,0,1,0,0,1,0,1,1 (0x34A), 4 cycles each; config scrambled mid-frame.
    task automatic test_8n1;
        logic [63:0] tx_w, busy_w, rdy_w;
        set_cfg(3, 3, 1'b0, 1'b0);
        run_frame(8'hA5, 42, 0, -1, -1, 1'b1, tx_w, busy_w, rdy_w);
        n_checks++;
        if (tx_w[0] !== 1'b0) begin
            n_fail++; $display("FAIL 8n1_first_low got=%b exp=0", tx_w[0]);
        end
        n_checks++;
        if (tx_w !== expand(16'h034A, 10, 3, 42)) begin
            n_fail++; $display("FAIL 8n1_tx got=%h exp=%h", tx_w, expand(16'h034A, 10, 3, 42));
        end
        n_checks++;
        if (busy_w !== span(0, 40)) begin
            n_fail++; $display("FAIL 8n1_busy got=%h exp=%h", busy_w, span(0, 40));
        end
        n_checks++;
        if (rdy_w !== span(40, 42)) begin
            n_fail++; $display("FAIL 8n1_ready got=%h exp=%h", rdy_w, span(40, 42));
        end
    endtask

    // div=0 7E1 0x83 -> 0,1100000,p=0,1 (0x206); div=0 5E2 0xE7 -> 0,11100,p=1,1,1 (0x1CE).
    task automatic test_parity;
        logic [63:0] tx_w, busy_w, rdy_w;
        set_cfg(0, 2, 1'b1, 1'b0);
        run_frame(8'h83, 12, 0, -1, -1, 1'b0, tx_w, busy_w, rdy_w);
        n_checks++;
        if (tx_w !== expand(16'h0206, 10, 0, 12)) begin
            n_fail++; $display("FAIL 7e1_tx got=%h exp=%h", tx_w, expand(16'h0206, 10, 0, 12));
        end
        n_checks++;
        if (busy_w !== span(0, 10)) begin
            n_fail++; $display("FAIL 7e1_busy got=%h exp=%h", busy_w, span(0, 10));
        end
        set_cfg(0, 0, 1'b1, 1'b1);
        run_frame(8'hE7, 11, 0, -1, -1, 1'b0, tx_w, busy_w, rdy_w);
        n_checks++;
        if (tx_w !== expand(16'h01CE, 9, 0, 11)) begin
            n_fail++; $display("FAIL 5e2_tx got=%h exp=%h", tx_w, expand(16'h01CE, 9, 0, 11));
        end
        n_checks++;
        if (rdy_w !== span(9, 11)) begin
            n_fail++; $display("FAIL 5e2_ready got=%h exp=%h", rdy_w, span(9, 11));
        end
    endtask

    // div=1 5N2 0x1F twice with valid held: 16-cycle frames separated only by the single
    // IDLE cycle in which the second handshake is taken.
    task automatic test_back_to_back;
        logic [63:0] tx_w, busy_w, rdy_w, frame, exp_tx;
        set_cfg(1, 0, 1'b0, 1'b1);
        run_frame(8'h1F, 34, 17, -1, -1, 1'b0, tx_w, busy_w, rdy_w);
        frame  = expand(16'h00FE, 8, 1, 16);
        exp_tx = frame | (frame << 17) | span(16, 17) | span(33, 34);
        n_checks++;
        if (tx_w !== exp_tx) begin
            n_fail++; $display("FAIL b2b_tx got=%h exp=%h", tx_w, exp_tx);
        end
        n_checks++;
        if (busy_w !== (span(0, 16) | span(17, 33))) begin
            n_fail++; $display("FAIL b2b_busy got=%h exp=%h", busy_w, span(0, 16) | span(17, 33));
        end
        n_checks++;
        if (rdy_w !== (span(16, 17) | span(33, 34))) begin
            n_fail++; $display("FAIL b2b_ready got=%h exp=%h", rdy_w, span(16, 17) | span(33, 34));
        end
    endtask

    // div=9 8N1, cfg_en_i dropped after cycle 25: line idles from the next edge, no handshakes.
    task automatic test_enable_abort;
        logic [63:0] tx_w, busy_w, rdy_w;
        logic        bad;
        set_cfg(9, 3, 1'b0, 1'b0);
        run_frame(8'h00, 30, 0, 24, -1, 1'b0, tx_w, busy_w, rdy_w);
        n_checks++;
        if (tx_w !== span(25, 30)) begin
            n_fail++; $display("FAIL en_abort_tx got=%h exp=%h", tx_w, span(25, 30));
        end
        n_checks++;
        if (busy_w !== span(0, 25)) begin
            n_fail++; $display("FAIL en_abort_busy got=%h exp=%h", busy_w, span(0, 25));
        end
        n_checks++;
        if (rdy_w !== 64'h0) begin
            n_fail++; $display("FAIL en_abort_ready got=%h exp=0", rdy_w);
        end
        tx_valid_i = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0 || tx_o !== 1'b1 || tx_ready_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL en_low_no_handshake got=%b exp=0", bad);
        end
        tx_valid_i = 1'b0;
        cfg_en_i   = 1'b1;
        #1;
        n_checks++;
        if (tx_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL en_return_ready got=%b exp=1", tx_ready_o);
        end
    endtask

    // div=3 8N1 0xA5 with a 1-cycle reset inside DATA, then a clean 0x3C frame (0x278).
    task automatic test_reset_abort;
        logic [63:0] tx_w, busy_w, rdy_w, exp_tx;
        set_cfg(3, 3, 1'b0, 1'b0);
        run_frame(8'hA5, 14, 0, -1, 10, 1'b0, tx_w, busy_w, rdy_w);
        exp_tx = expand(16'h034A, 10, 3, 11) | span(11, 14);
        n_checks++;
        if (tx_w !== exp_tx) begin
            n_fail++; $display("FAIL rst_abort_tx got=%h exp=%h", tx_w, exp_tx);
        end
        n_checks++;
        if (busy_w !== span(0, 11)) begin
            n_fail++; $display("FAIL rst_abort_busy got=%h exp=%h", busy_w, span(0, 11));
        end
        n_checks++;
        if (rdy_w !== span(12, 14)) begin
            n_fail++; $display("FAIL rst_abort_ready got=%h exp=%h", rdy_w, span(12, 14));
        end
        run_frame(8'h3C, 42, 0, -1, -1, 1'b0, tx_w, busy_w, rdy_w);
        n_checks++;
        if (tx_w !== expand(16'h0278, 10, 3, 42)) begin
            n_fail++; $display("FAIL rst_next_tx got=%h exp=%h", tx_w, expand(16'h0278, 10, 3, 42));
        end
        n_checks++;
        if (busy_w !== span(0, 40)) begin
            n_fail++; $display("FAIL rst_next_busy got=%h exp=%h", busy_w, span(0, 40));
        end
    endtask

`ifdef UDMA_UART_TX_CTS_EN
    // cts_ni high blocks; low gives a handshake 3 edges later; rising mid-frame does not abort.
    task automatic test_cts;
        logic [63:0] tx_w, exp_tx;
        logic        blocked;
        set_cfg(0, 3, 1'b0, 1'b0);
        @(negedge clk_i);
        cts_ni     = 1'b1;
        tx_data_i  = 8'hA5;
        tx_valid_i = 1'b1;
        blocked    = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (tx_ready_o !== 1'b0 || tx_o !== 1'b1) blocked = 1'b1;
        end
        n_checks++;
        if (blocked !== 1'b0) begin
            n_fail++; $display("FAIL cts_blocked got=%b exp=0", blocked);
        end
        cts_ni = 1'b0;
        tx_w   = '0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk_i);
            tx_w[j] = tx_o;
            if (j == 2) begin
                cts_ni     = 1'b1;
                tx_valid_i = 1'b0;
            end
        end
        exp_tx = span(0, 2) | (expand(16'h034A, 10, 0, 12) << 2);
        n_checks++;
        if (tx_w !== exp_tx) begin
            n_fail++; $display("FAIL cts_frame_tx got=%h exp=%h", tx_w, exp_tx);
        end
        cts_ni = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask
`endif

    initial begin
        rstn_i     = 1'b0;
        cfg_en_i   = 1'b1;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        set_cfg(3, 3, 1'b0, 1'b0);
`ifdef UDMA_UART_TX_CTS_EN
        cts_ni = 1'b0;
`endif
        test_reset;
        test_8n1;
        test_parity;
        test_back_to_back;
        test_enable_abort;
        test_reset_abort;
`ifdef UDMA_UART_TX_CTS_EN
        test_cts;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_uart_tx.md
UDMA_UART_TX -- requirements
Module: udma_uart_tx

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, setting the baud divider width.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port tx_o  output  1  serial line, idle high.
REQ-005 SHALL have port cfg_div_i  input  DIV_WIDTH  bit period minus one, in clk_i cycles.
REQ-006 SHALL have ports cfg_en_i  input  1  enable; cfg_parity_en_i  input  1  even parity bit enable.
REQ-007 SHALL have ports cfg_bits_i  input  2  data bits = 5 + value; cfg_stop_bits_i  input  1  0 = 1 stop bit, 1 = 2 stop bits.
REQ-008 SHALL have ports tx_data_i  input  8, tx_valid_i  input  1, tx_ready_o  output  1  valid/ready byte input.
REQ-009 SHALL have port busy_o  output  1  high whenever state != IDLE.

Function
REQ-010 SHALL implement states IDLE, START_BIT, DATA, PARITY, STOP_BIT.
REQ-011 SHALL drive tx_ready_o = (state == IDLE) & cfg_en_i, combinationally.
REQ-012 SHALL treat tx_valid_i & tx_ready_o at a rising edge as a handshake.
- On a handshake, SHALL latch tx_data_i, cfg_div_i, cfg_bits_i, cfg_parity_en_i and cfg_stop_bits_i.
- On a handshake, SHALL move to START_BIT.
- Config changes during a frame SHALL have no effect until the next frame.
REQ-013 SHALL register tx_o. It SHALL go low on the first cycle after the handshake.
REQ-014 SHALL hold each bit on tx_o for exactly latched div + 1 cycles, timed by a counter that resets at every bit boundary.
REQ-015 DATA SHALL shift out bits [n-1:0] LSB first, n = 5 + cfg_bits. Bits above n-1 SHALL be ignored.
REQ-016 The PARITY state SHALL be entered only if parity is enabled.
- It SHALL send the XOR of the n data bits, which is even parity.
REQ-017 STOP_BIT SHALL drive 1 for one bit period, or for two bit periods if cfg_stop_bits = 1.
- It SHALL then return to IDLE.
REQ-018 Frame length SHALL be (1 + n + p + s) × (div + 1) cycles, where p is the parity bit count (0/1) and s is the stop bit count (1/2).
REQ-019 Back-to-back frames: tx_ready_o SHALL rise in the first IDLE cycle.
- If tx_valid_i is held, the next start bit SHALL follow with no extra idle cycle.
REQ-020 div = 0 SHALL give 1-cycle bits. div = all-ones SHALL not overflow the counter.
REQ-021 cfg_en_i low in any state SHALL force IDLE on the next edge.
- The in-flight frame SHALL be aborted.
- tx_o SHALL be 1 from that edge.
- No handshake SHALL be accepted while cfg_en_i is low.

Reset
REQ-022 With rstn_i low at a rising edge, SHALL set state to IDLE, tx_o to 1, the counters to 0 and the data register to 0xFF.
REQ-023 Reset outputs SHALL be: tx_o = 1, busy_o = 0, tx_ready_o = 0 during reset.
- tx_ready_o SHALL follow REQ-011 after reset.
REQ-024 Reset asserted mid-frame SHALL abort the frame identically to REQ-021.

Configuration
REQ-025 Macro UDMA_UART_TX_CTS_EN, when defined, SHALL add input cts_ni (1 bit, active-low clear-to-send).
- The synchronizer SHALL be 2 flops, reset to 1.
- tx_ready_o SHALL additionally require the synchronized cts_ni = 0.
- A frame in progress SHALL always complete regardless of cts_ni.
REQ-026 Without UDMA_UART_TX_CTS_EN, SHALL have no cts_ni port and no synchronizer; behaviour SHALL be exactly REQ-011.

Structure
REQ-027 SHALL take the state enum and the cfg_bits/stop encodings from shared package udma_uart_pkg.
- The UART receiver SHALL use the same package.
REQ-028 MAY instantiate one sub-module, udma_uart_baudgen: a bit-period counter with restart input, div input and tick output.
- No other sub-modules SHALL be used.

Verification
REQ-029 div = 3, 8N1, tx_data_i = 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; busy_o high 40 cycles; tx_ready_o low 40 cycles.
REQ-030 div = 0, 7E1 (cfg_bits = 2, parity on), 0x83 -> start, 1100000, parity 0, stop; 10 cycles total; bit 7 ignored.
REQ-031 div = 1, 5N2, 0x1F with tx_valid_i held for 2 bytes -> each frame 16 cycles; second start bit directly after the 4-cycle stop; no extra idle cycle.
REQ-032 div = 9, cfg_en_i dropped in cycle 25 of a frame -> tx_o = 1 and busy_o = 0 from the next edge; tx_ready_o stays 0 until cfg_en_i returns.
REQ-033 rstn_i low for 1 cycle during DATA -> tx_o = 1, IDLE; the next handshake sends a full correct frame.
REQ-034 With UDMA_UART_TX_CTS_EN, cts_ni = 1 -> tx_ready_o = 0 and tx_o stays 1.
- cts_ni = 0 -> handshake 3 cycles later.
- cts_ni rising mid-frame -> the frame still completes.
